// File: rtl/alut_pkg.sv
// Shared types for the ALUT address checker: FSM states, command code
// and table-entry field offsets for the {valid,time,port,addr} word.
package alut_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC_CHK,
        RD_DST,
        EVAL_DST,
        RD_SRC,
        EVAL_SRC,
        WR_SRC,
        DONE
    } state_t;

    localparam logic [1:0] CMD_CHECK = 2'b01;

    function automatic int port_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int time_lsb(input int addr_w, input int port_w);
        return addr_w + port_w;
    endfunction

    function automatic int valid_bit(input int addr_w, input int port_w,
                                     input int time_w);
        return addr_w + port_w + time_w;
    endfunction

endpackage

// File: rtl/alut_hash_fold.sv
// XOR-fold of an address into HASH_W-bit chunks; the top chunk is
// zero-padded when ADDR_W is not a multiple of HASH_W.
module alut_hash_fold #(
    parameter int ADDR_W = 48,
    parameter int HASH_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [HASH_W-1:0] hash
);

    localparam int NCH   = (ADDR_W + HASH_W - 1) / HASH_W;
    localparam int PAD_W = NCH * HASH_W;

    logic [PAD_W-1:0] padded;

    always_comb begin
        padded = '0;
        padded[ADDR_W-1:0] = addr;
        hash = '0;
        for (int i = 0; i < NCH; i++) begin
            hash = hash ^ padded[i*HASH_W +: HASH_W];
        end
    end

endmodule

// File: rtl/alut_addr_checker_p.sv
// ALUT destination lookup and source learning with inline age check.
// Optional ALUT_BCAST_EN: broadcast destinations skip the table lookup.
module alut_addr_checker_p
    import alut_pkg::*;
#(
    parameter int ADDR_W    = 48,
    parameter int NUM_PORTS = 4,
    parameter int HASH_W    = 8,
    parameter int TIME_W    = 32,
    parameter int PORT_W    = $clog2(NUM_PORTS),
    parameter int ENTRY_W   = 1 + TIME_W + PORT_W + ADDR_W
) (
    input  logic                 pclk,
    input  logic                 n_p_reset,
    input  logic [1:0]           command,
    input  logic [ADDR_W-1:0]    mac_addr,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [ADDR_W-1:0]    s_addr,
    input  logic [PORT_W-1:0]    s_port,
    input  logic [TIME_W-1:0]    curr_time,
    input  logic [TIME_W-1:0]    max_age,
    input  logic                 clear_reused,
    input  logic [ENTRY_W-1:0]   mem_rdata,
    output logic [NUM_PORTS:0]   d_port,
    output logic                 done,
    output logic                 add_check_active,
    output logic                 cmd_dropped,
    output logic [HASH_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [ENTRY_W-1:0]   mem_wdata,
    output logic                 reused,
    output logic [ADDR_W-1:0]    lst_inv_addr,
    output logic [PORT_W-1:0]    lst_inv_port
);

    localparam int P_LSB = port_lsb(ADDR_W);
    localparam int T_LSB = time_lsb(ADDR_W, PORT_W);
    localparam int V_BIT = valid_bit(ADDR_W, PORT_W, TIME_W);

    localparam logic [NUM_PORTS:0] ALL_PORTS = {1'b0, {NUM_PORTS{1'b1}}};
    localparam logic [NUM_PORTS:0] CPU_PORT  = {1'b1, {NUM_PORTS{1'b0}}};
    localparam logic [NUM_PORTS:0] ONE       = {{NUM_PORTS{1'b0}}, 1'b1};

    state_t state, next_state;

    logic [HASH_W-1:0]  d_hash, s_hash;
    logic [HASH_W-1:0]  nxt_addr;
    logic               nxt_we;
    logic               rd_valid;
    logic [ADDR_W-1:0]  rd_addr;
    logic [PORT_W-1:0]  rd_port;
    logic [TIME_W-1:0]  rd_time;
    logic [TIME_W-1:0]  age;
    logic               hit;
    logic               mac_hit;
    logic               bcast;
    logic [NUM_PORTS:0] own_bit;
    logic [NUM_PORTS:0] flood;
    logic [NUM_PORTS:0] hit_port;

    alut_hash_fold #(.ADDR_W(ADDR_W), .HASH_W(HASH_W)) u_hash_d (
        .addr (d_addr),
        .hash (d_hash)
    );

    alut_hash_fold #(.ADDR_W(ADDR_W), .HASH_W(HASH_W)) u_hash_s (
        .addr (s_addr),
        .hash (s_hash)
    );

    assign rd_valid = mem_rdata[V_BIT];
    assign rd_addr  = mem_rdata[ADDR_W-1:0];
    assign rd_port  = mem_rdata[P_LSB +: PORT_W];
    assign rd_time  = mem_rdata[T_LSB +: TIME_W];

    // Modular difference keeps the age correct across curr_time wrap
    assign age      = curr_time - rd_time;
    assign hit      = rd_valid && (rd_addr == d_addr) && (age <= max_age);
    assign mac_hit  = (d_addr == mac_addr);
    assign bcast    = &d_addr;
    assign own_bit  = ONE << s_port;
    assign flood    = ALL_PORTS & ~own_bit;
    assign hit_port = ALL_PORTS & (ONE << rd_port) & ~own_bit;

    assign add_check_active = (state != IDLE);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (command == CMD_CHECK) next_state = MAC_CHK;
            MAC_CHK: begin
                if (mac_hit) next_state = DONE;
`ifdef ALUT_BCAST_EN
                else if (bcast) next_state = RD_SRC;
`endif
                else next_state = RD_DST;
            end
            RD_DST:   next_state = EVAL_DST;
            EVAL_DST: next_state = RD_SRC;
            RD_SRC:   next_state = EVAL_SRC;
            EVAL_SRC: next_state = WR_SRC;
            WR_SRC:   next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Memory controls are registered from the next state so they are
    // stable for the whole cycle the FSM spends in that state
    always_comb begin
        nxt_addr = d_hash;
        nxt_we   = 1'b0;
        unique case (next_state)
            RD_SRC:  nxt_addr = s_hash;
            WR_SRC: begin
                nxt_addr = s_hash;
                nxt_we   = 1'b1;
            end
            default: nxt_addr = d_hash;
        endcase
    end

    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            state        <= IDLE;
            d_port       <= ALL_PORTS;
            done         <= 1'b0;
            cmd_dropped  <= 1'b0;
            reused       <= 1'b0;
            lst_inv_addr <= '0;
            lst_inv_port <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
        end else begin
            state       <= next_state;
            done        <= (state == DONE);
            cmd_dropped <= (state != IDLE) && (command == CMD_CHECK);
            mem_addr    <= nxt_addr;
            mem_we      <= nxt_we;
            mem_wdata   <= {1'b1, curr_time, s_port, s_addr};

            if (state == MAC_CHK) begin
                if (mac_hit) d_port <= CPU_PORT;
`ifdef ALUT_BCAST_EN
                else if (bcast) d_port <= flood;
`endif
            end
            if (state == EVAL_DST) d_port <= hit ? hit_port : flood;

            if (state == EVAL_SRC && rd_valid && rd_addr != s_addr) begin
                reused       <= 1'b1;
                lst_inv_addr <= rd_addr;
                lst_inv_port <= rd_port;
            end else if (clear_reused) begin
                reused <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alut_addr_checker_p.sv
// Directed bench for alut_addr_checker_p with a 1-cycle-latency RAM model.
// Expected values are hand-computed for the default parameters.
module tb_alut_addr_checker_p;

    logic        pclk;
    logic        n_p_reset;
    logic [1:0]  command;
    logic [47:0] mac_addr, d_addr, s_addr;
    logic [1:0]  s_port;
    logic [31:0] curr_time, max_age;
    logic        clear_reused;
    logic [82:0] mem_rdata;
    logic [4:0]  d_port;
    logic        done, add_check_active, cmd_dropped;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [82:0] mem_wdata;
    logic        reused;
    logic [47:0] lst_inv_addr;
    logic [1:0]  lst_inv_port;

    int errs   = 0;
    int checks = 0;

    logic [82:0] mem [256];
    int          wr_cnt = 0;
    logic [7:0]  last_waddr;
    logic [82:0] last_wdata;
    logic        poke, clr;
    logic [7:0]  poke_a;
    logic [82:0] poke_d;

    alut_addr_checker_p dut (
        .pclk             (pclk),
        .n_p_reset        (n_p_reset),
        .command          (command),
        .mac_addr         (mac_addr),
        .d_addr           (d_addr),
        .s_addr           (s_addr),
        .s_port           (s_port),
        .curr_time        (curr_time),
        .max_age          (max_age),
        .clear_reused     (clear_reused),
        .mem_rdata        (mem_rdata),
        .d_port           (d_port),
        .done             (done),
        .add_check_active (add_check_active),
        .cmd_dropped      (cmd_dropped),
        .mem_addr         (mem_addr),
        .mem_we           (mem_we),
        .mem_wdata        (mem_wdata),
        .reused           (reused),
        .lst_inv_addr     (lst_inv_addr),
        .lst_inv_port     (lst_inv_port)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (poke) begin
            mem[poke_a] <= poke_d;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt     = wr_cnt + 1;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    function automatic logic [82:0] ent(input logic [31:0] t,
                                        input logic [1:0] p,
                                        input logic [47:0] a);
        return {1'b1, t, p, a};
    endfunction

    task automatic put(input logic [7:0] a, input logic [82:0] d);
        @(negedge pclk);
        poke_a = a;
        poke_d = d;
        poke   = 1'b1;
        @(negedge pclk);
        poke   = 1'b0;
    endtask

    task automatic run_cmd(output int lat);
        @(negedge pclk);
        command = 2'b01;
        @(posedge pclk);
        @(negedge pclk);
        command = 2'b00;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge pclk);
            @(negedge pclk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (d_port !== 5'b0_1111) begin
            errs++; $display("FAIL reset_d_port got=%b exp=01111", d_port);
        end
        checks++;
        if ({done, cmd_dropped, reused, mem_we, add_check_active} !== 5'b0) begin
            errs++; $display("FAIL reset_flags got=%b exp=00000",
                {done, cmd_dropped, reused, mem_we, add_check_active});
        end
        checks++;
        if (mem_addr !== 8'h00 || lst_inv_addr !== 48'h0 || lst_inv_port !== 2'd0) begin
            errs++; $display("FAIL reset_addr got=%h/%h/%h exp=0/0/0",
                mem_addr, lst_inv_addr, lst_inv_port);
        end
    endtask

    task automatic test_mac_hit;
        int lat, w0;
        w0 = wr_cnt;
        d_addr = 48'h0000_1234_5678;
        s_addr = 48'h0000_0000_00E1;
        s_port = 2'd0;
        run_cmd(lat);
        checks++;
        if (d_port !== 5'b1_0000) begin
            errs++; $display("FAIL mac_d_port got=%b exp=10000", d_port);
        end
        checks++;
        if (lat !== 2) begin
            errs++; $display("FAIL mac_latency got=%0d exp=2", lat);
        end
        checks++;
        if (wr_cnt !== w0) begin
            errs++; $display("FAIL mac_no_write got=%0d exp=0", wr_cnt - w0);
        end
    endtask

    task automatic test_learn_empty;
        int lat, w0;
        w0 = wr_cnt;
        d_addr = 48'hA;
        s_addr = 48'hB;
        s_port = 2'd1;
        curr_time = 32'd1000;
        run_cmd(lat);
        checks++;
        if (d_port !== 5'b0_1101) begin
            errs++; $display("FAIL learn_d_port got=%b exp=01101", d_port);
        end
        checks++;
        if (lat !== 7) begin
            errs++; $display("FAIL learn_latency got=%0d exp=7", lat);
        end
        checks++;
        if (wr_cnt - w0 !== 1 || last_waddr !== 8'h0B) begin
            errs++; $display("FAIL learn_waddr got=%0d@%h exp=1@0b",
                wr_cnt - w0, last_waddr);
        end
        checks++;
        if (last_wdata !== {1'b1, 32'd1000, 2'd1, 48'hB}) begin
            errs++; $display("FAIL learn_wdata got=%h exp=%h", last_wdata,
                {1'b1, 32'd1000, 2'd1, 48'hB});
        end
        checks++;
        if (reused !== 1'b0) begin
            errs++; $display("FAIL learn_reused got=%b exp=0", reused);
        end
    endtask

    task automatic test_age;
        int lat;
        put(8'h0A, ent(32'd100, 2'd3, 48'hA));
        d_addr = 48'hA;
        s_addr = 48'hC;
        s_port = 2'd0;
        curr_time = 32'd150;
        max_age = 32'd50;
        run_cmd(lat);
        checks++;
        if (d_port !== 5'b0_1000) begin
            errs++; $display("FAIL age_edge_hit got=%b exp=01000", d_port);
        end
        curr_time = 32'd151;
        run_cmd(lat);
        checks++;
        if (d_port !== 5'b0_1110) begin
            errs++; $display("FAIL age_expired got=%b exp=01110", d_port);
        end
        put(8'h0A, ent(32'hFFFF_FFF0, 2'd2, 48'hA));
        curr_time = 32'h10;
        max_age = 32'h20;
        run_cmd(lat);
        checks++;
        if (d_port !== 5'b0_0100) begin
            errs++; $display("FAIL age_wrap got=%b exp=00100", d_port);
        end
        put(8'h0A, ent(32'h8, 2'd1, 48'hA));
        s_port = 2'd1;
        run_cmd(lat);
        checks++;
        if (d_port !== 5'b0_0000) begin
            errs++; $display("FAIL own_port got=%b exp=00000", d_port);
        end
    endtask

    task automatic test_reused;
        int lat;
        put(8'h0B, ent(32'd5, 2'd2, 48'h0100_0000_000A));
        d_addr = 48'hA;
        s_addr = 48'hB;
        s_port = 2'd3;
        @(negedge pclk);
        command = 2'b01;
        @(posedge pclk);
        @(negedge pclk);
        command = 2'b00;
        repeat (4) @(posedge pclk);
        @(negedge pclk);
        checks++;
        if (reused !== 1'b0) begin
            errs++; $display("FAIL reused_before got=%b exp=0", reused);
        end
        clear_reused = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        clear_reused = 1'b0;
        checks++;
        if (reused !== 1'b1) begin
            errs++; $display("FAIL reused_set_wins got=%b exp=1", reused);
        end
        checks++;
        if (lst_inv_addr !== 48'h0100_0000_000A || lst_inv_port !== 2'd2) begin
            errs++; $display("FAIL lst_inv got=%h/%0d exp=01000000000a/2",
                lst_inv_addr, lst_inv_port);
        end
        lat = 99;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat == 99 || last_wdata !== {1'b1, curr_time, 2'd3, 48'hB}) begin
            errs++; $display("FAIL reused_write got=%h exp=%h", last_wdata,
                {1'b1, curr_time, 2'd3, 48'hB});
        end
        clear_reused = 1'b1;
        @(negedge pclk);
        clear_reused = 1'b0;
        checks++;
        if (reused !== 1'b0 || lst_inv_addr !== 48'h0100_0000_000A) begin
            errs++; $display("FAIL reused_clear got=%b/%h exp=0/01000000000a",
                reused, lst_inv_addr);
        end
    endtask

    task automatic test_bcast;
        int lat, w0, exp_lat;
`ifdef ALUT_BCAST_EN
        exp_lat = 5;
`else
        exp_lat = 7;
`endif
        w0 = wr_cnt;
        d_addr = 48'hFFFF_FFFF_FFFF;
        s_addr = 48'hD;
        s_port = 2'd2;
        run_cmd(lat);
        checks++;
        if (d_port !== 5'b0_1011) begin
            errs++; $display("FAIL bcast_d_port got=%b exp=01011", d_port);
        end
        checks++;
        if (lat !== exp_lat) begin
            errs++; $display("FAIL bcast_latency got=%0d exp=%0d", lat, exp_lat);
        end
        checks++;
        if (wr_cnt - w0 !== 1 || last_waddr !== 8'h0D) begin
            errs++; $display("FAIL bcast_learn got=%0d@%h exp=1@0d",
                wr_cnt - w0, last_waddr);
        end
    endtask

    task automatic test_back_to_back;
        int w0, ndone;
        w0 = wr_cnt;
        d_addr = 48'hA;
        s_addr = 48'hB;
        s_port = 2'd0;
        @(negedge pclk);
        command = 2'b01;
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk);
        command = 2'b00;
        checks++;
        if (cmd_dropped !== 1'b1) begin
            errs++; $display("FAIL dropped_pulse got=%b exp=1", cmd_dropped);
        end
        @(negedge pclk);
        checks++;
        if (cmd_dropped !== 1'b0) begin
            errs++; $display("FAIL dropped_width got=%b exp=0", cmd_dropped);
        end
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge pclk);
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 1 || wr_cnt - w0 !== 1) begin
            errs++; $display("FAIL dropped_single got=%0d/%0d exp=1/1",
                ndone, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid;
        int w0, ndone;
        w0 = wr_cnt;
        d_addr = 48'hA;
        s_addr = 48'h1C;
        s_port = 2'd1;
        @(negedge pclk);
        command = 2'b01;
        @(posedge pclk);
        @(negedge pclk);
        command = 2'b00;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        n_p_reset = 1'b0;
        #1;
        checks++;
        if (add_check_active !== 1'b0 || mem_we !== 1'b0 || d_port !== 5'b0_1111) begin
            errs++; $display("FAIL midreset_state got=%b/%b/%b exp=0/0/01111",
                add_check_active, mem_we, d_port);
        end
        @(negedge pclk);
        n_p_reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0 || wr_cnt !== w0) begin
            errs++; $display("FAIL midreset_nowrite got=%0d/%0d exp=0/0",
                ndone, wr_cnt - w0);
        end
    endtask

    initial begin
        n_p_reset    = 1'b0;
        command      = 2'b00;
        mac_addr     = 48'h0000_1234_5678;
        d_addr       = '0;
        s_addr       = '0;
        s_port       = '0;
        curr_time    = '0;
        max_age      = 32'd1000;
        clear_reused = 1'b0;
        poke         = 1'b0;
        poke_a       = '0;
        poke_d       = '0;
        clr          = 1'b1;
        repeat (3) @(negedge pclk);
        test_reset;
        n_p_reset = 1'b1;
        @(negedge pclk);
        clr = 1'b0;
        @(negedge pclk);
        test_mac_hit;
        test_learn_empty;
        test_age;
        test_reused;
        test_bcast;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
